// File: rtl/ps2_pkg.sv
// Shared types and set-2 scan-code constants for the PS/2 keyboard event path.
package ps2_pkg;

  typedef struct packed {
    logic       extended;
    logic       rel;
    logic [7:0] code;
  } key_event_t;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} ctrl_state_t;

  localparam logic [7:0] SC_EXT          = 8'hE0;
  localparam logic [7:0] SC_BRK          = 8'hF0;
  localparam logic [7:0] SC_PAUSE        = 8'hE1;
  localparam logic [7:0] SC_BAT          = 8'hAA;
  localparam logic [7:0] SC_ACK          = 8'hFA;
  localparam logic [7:0] SC_RESEND       = 8'hFE;
  localparam logic [7:0] SC_ECHO         = 8'hEE;
  localparam logic [7:0] SC_FAKE_SHIFT_L = 8'h12;
  localparam logic [7:0] SC_FAKE_SHIFT_R = 8'h59;
  localparam logic [7:0] SC_PAUSE_CODE   = 8'h77;
  localparam logic [2:0] PAUSE_SKIP      = 3'd7;

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == SC_FAKE_SHIFT_L) || (b == SC_FAKE_SHIFT_R);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through FIFO of key events; head is valid whenever not empty.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  key_event_t             din_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output key_event_t             head_o
);

  localparam int AW = $clog2(DEPTH);

  key_event_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Turns the raw set-2 byte stream into make/break key events and queues them
// for the key-matrix logic; tracks overflow and protocol errors.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic [7:0]                  scan_code,
  input  logic                        scan_code_ready,
  input  logic                        scan_code_error,
  output logic                        key_valid,
  output logic [7:0]                  key_code,
  output logic                        key_extended,
  output logic                        key_release,
  input  logic                        key_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  input  logic                        overflow_clr,
  output logic [7:0]                  err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ctrl_state_t   state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    err_q;
  logic          ovf_q;
  key_event_t    last_q;

  logic          emit;
  logic          byte_err;
  logic          timeout;
  logic          err_inc;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          drop;
  key_event_t    ev;
  key_event_t    head;
  key_event_t    shown;

  assign timeout = (state_q != IDLE) && !scan_code_ready && !scan_code_error &&
                   (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    if (scan_code_error || timeout) begin
      state_d = IDLE;
    end else if (scan_code_ready) begin
      case (state_q)
        IDLE: begin
          case (scan_code)
            SC_EXT:   state_d = EXT;
            SC_BRK:   state_d = BRK;
            SC_PAUSE: begin
              state_d = PAUSE;
              skip_d  = PAUSE_SKIP;
            end
            default:  state_d = IDLE;
          endcase
        end
        EXT:     state_d = (scan_code == SC_BRK) ? EXT_BRK : IDLE;
        PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Mealy decode: the event is pushed on the same edge that consumes its final byte.
  always_comb begin
    emit     = 1'b0;
    byte_err = 1'b0;
    ev       = '{extended: 1'b0, rel: 1'b0, code: scan_code};
    if (scan_code_ready && !scan_code_error) begin
      case (state_q)
        IDLE: begin
          case (scan_code)
            SC_EXT, SC_BRK, SC_PAUSE, SC_BAT, SC_ACK, SC_RESEND, SC_ECHO: ;
            8'h00, 8'hFF: byte_err = 1'b1;
            default:      emit     = 1'b1;
          endcase
        end
        EXT: begin
          if (scan_code != SC_BRK && !is_fake_shift(scan_code)) begin
            emit        = 1'b1;
            ev.extended = 1'b1;
          end
        end
        BRK: begin
          emit   = 1'b1;
          ev.rel = 1'b1;
        end
        EXT_BRK: begin
          if (!is_fake_shift(scan_code)) begin
            emit        = 1'b1;
            ev.extended = 1'b1;
            ev.rel      = 1'b1;
          end
        end
        PAUSE: begin
          if (skip_q == 3'd1) begin
            emit = 1'b1;
            ev   = '{extended: 1'b1, rel: 1'b0, code: SC_PAUSE_CODE};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (scan_code_ready || scan_code_error || timeout || state_q == IDLE) tcnt_d = '0;
    else                                                                  tcnt_d = tcnt_q + TW'(1);
  end

  assign err_inc = scan_code_error | timeout | byte_err;
  assign pop     = ~fifo_empty & key_ready;
  assign drop    = emit & fifo_full & ~pop;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tcnt_q <= '0;
      err_q  <= '0;
      ovf_q  <= 1'b0;
      last_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
      if (drop)              ovf_q <= 1'b1;
      else if (overflow_clr) ovf_q <= 1'b0;
      if (!fifo_empty) last_q <= head;
    end
  end

  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .nreset  (nreset),
    .push_i  (emit),
    .pop_i   (pop),
    .din_i   (ev),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (head)
  );

  // Outputs keep showing the last head once the FIFO drains.
  assign shown        = fifo_empty ? last_q : head;
  assign key_valid    = ~fifo_empty;
  assign key_code     = shown.code;
  assign key_extended = shown.extended;
  assign key_release  = shown.rel;
  assign overflow     = ovf_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Randomised and directed bench for ps2_kbd_ctrl against a byte-sequence/queue model.
module tb_ps2_kbd_ctrl;

  localparam int DEPTH = 8;
  localparam int TMO   = 40;

  logic       clk = 1'b0;
  logic       nreset;
  logic [7:0] scan_code;
  logic       scan_code_ready;
  logic       scan_code_error;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_release;
  logic       key_ready;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       overflow_clr;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .scan_code       (scan_code),
    .scan_code_ready (scan_code_ready),
    .scan_code_error (scan_code_error),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .key_extended    (key_extended),
    .key_release     (key_release),
    .key_ready       (key_ready),
    .fifo_count      (fifo_count),
    .overflow        (overflow),
    .overflow_clr    (overflow_clr),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  // Model: pending prefix bytes, queued events {ext, rel, code}, sticky flags.
  logic [7:0] m_seq[$];
  logic [9:0] m_q[$];
  logic [9:0] m_last;
  int         m_quiet;
  int         m_err;
  logic       m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_seq.delete();
    m_q.delete();
    m_last  = '0;
    m_quiet = 0;
    m_err   = 0;
    m_ovf   = 1'b0;
  endtask

  // Classify the whole pending byte sequence once the new byte is appended.
  task automatic m_byte(input logic [7:0] b, output bit emit, output logic [9:0] ev, output bit bad);
    emit = 0;
    ev   = '0;
    bad  = 0;
    m_seq.push_back(b);
    if (m_seq[0] == 8'hE1) begin
      if (m_seq.size() == 8) begin
        emit = 1;
        ev   = {2'b10, 8'h77};
        m_seq.delete();
      end
    end else if (m_seq.size() == 1) begin
      case (b)
        8'hE0, 8'hF0: ;
        8'hAA, 8'hFA, 8'hFE, 8'hEE: m_seq.delete();
        8'h00, 8'hFF: begin
          bad = 1;
          m_seq.delete();
        end
        default: begin
          emit = 1;
          ev   = {2'b00, b};
          m_seq.delete();
        end
      endcase
    end else if (m_seq[0] == 8'hF0) begin
      emit = 1;
      ev   = {2'b01, b};
      m_seq.delete();
    end else if (m_seq.size() == 2 && b == 8'hF0) begin
      // E0 F0: wait for the key byte
    end else begin
      if (b != 8'h12 && b != 8'h59) begin
        emit = 1;
        ev   = {1'b1, (m_seq.size() == 3), b};
      end
      m_seq.delete();
    end
  endtask

  task automatic m_step();
    bit         emit = 0;
    bit         bad  = 0;
    bit         pop;
    bit         drop = 0;
    logic [9:0] ev   = '0;
    pop = (m_q.size() > 0) && key_ready;
    if (m_q.size() > 0) m_last = m_q[0];
    if (scan_code_error) begin
      m_seq.delete();
      bad     = 1;
      m_quiet = 0;
    end else if (scan_code_ready) begin
      m_byte(scan_code, emit, ev, bad);
      m_quiet = 0;
    end else if (m_seq.size() > 0) begin
      m_quiet++;
      if (m_quiet == TMO) begin
        m_seq.delete();
        bad     = 1;
        m_quiet = 0;
      end
    end else begin
      m_quiet = 0;
    end
    if (bad && m_err < 255) m_err++;
    if (emit && m_q.size() == DEPTH && !pop) drop = 1;
    if (pop) void'(m_q.pop_front());
    if (emit && !drop) m_q.push_back(ev);
    if (drop) m_ovf = 1'b1;
    else if (overflow_clr) m_ovf = 1'b0;
  endtask

  task automatic compare();
    logic [9:0] h;
    h = (m_q.size() > 0) ? m_q[0] : m_last;
    chk("key_valid", key_valid, (m_q.size() > 0));
    chk("key_code", key_code, h[7:0]);
    chk("key_extended", key_extended, h[9]);
    chk("key_release", key_release, h[8]);
    chk("fifo_count", fifo_count, m_q.size());
    chk("overflow", overflow, m_ovf);
    chk("err_count", err_count, m_err);
  endtask

  task automatic cycle();
    m_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    scan_code_ready = 1'b0;
    scan_code_error = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic send(input logic [7:0] b);
    scan_code       = b;
    scan_code_ready = 1'b1;
    cycle();
    scan_code_ready = 1'b0;
  endtask

  task automatic do_reset();
    nreset          = 1'b0;
    scan_code_ready = 1'b0;
    scan_code_error = 1'b0;
    overflow_clr    = 1'b0;
    m_reset();
    #2;
    chk("rst_valid", key_valid, 0);
    chk("rst_code", {key_extended, key_release, key_code}, 10'h000);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", err_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    cycle();
  endtask

  function automatic logic [7:0] pick_byte();
    logic [7:0] tbl [16] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'hAA, 8'hFA, 8'hFE,
                             8'hEE, 8'h00, 8'hFF, 8'h1C, 8'h75, 8'h77, 8'h14, 8'h7C};
    if ($urandom_range(0, 2) == 0) return 8'($urandom);
    return tbl[$urandom_range(0, 15)];
  endfunction

  initial begin
    scan_code    = '0;
    key_ready    = 1'b1;
    overflow_clr = 1'b0;
    do_reset();

    // make then break
    send(8'h1C);
    chk("t1_make_valid", key_valid, 1);
    chk("t1_make_evt", {key_extended, key_release, key_code}, 10'h01C);
    send(8'hF0);
    send(8'h1C);
    chk("t1_brk_valid", key_valid, 1);
    chk("t1_brk_evt", {key_extended, key_release, key_code}, 10'h11C);

    // extended break, fake shift dropped
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t2_extbrk_evt", {key_extended, key_release, key_code}, 10'h375);
    send(8'hE0); send(8'h12);
    chk("t2_fake_shift_valid", key_valid, 0);
    send(8'hE0); send(8'h7C);
    chk("t2_ext_evt", {key_extended, key_release, key_code}, 10'h27C);

    // Pause: one event only after the eighth byte
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    chk("t3_pause_pending", key_valid, 0);
    send(8'h77);
    chk("t3_pause_evt", {key_valid, key_extended, key_release, key_code}, 11'h677);
    chk("t3_pause_err", err_count, 0);
    idle(3);

    // overflow
    key_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(8'h15 + 8'(i));
    chk("t4_full_count", fifo_count, 8);
    chk("t4_ovf_set", overflow, 1);
    chk("t4_head", key_code, 8'h15);
    key_ready = 1'b1;
    send(8'h2A);
    key_ready = 1'b0;
    chk("t4_pushpop_count", fifo_count, 8);
    chk("t4_pushpop_ovf", overflow, 1);
    overflow_clr = 1'b1;
    idle(1);
    overflow_clr = 1'b0;
    chk("t4_ovf_clr", overflow, 0);
    overflow_clr = 1'b1;
    send(8'h2B);
    overflow_clr = 1'b0;
    chk("t4_set_wins", overflow, 1);
    key_ready = 1'b1;
    idle(10);
    chk("t4_drained", fifo_count, 0);

    // timeout of a partial break
    send(8'hF0);
    idle(TMO + 2);
    chk("t5_timeout_err", err_count, 1);
    send(8'h1C);
    chk("t5_after_evt", {key_valid, key_extended, key_release, key_code}, 11'h41C);

    // receive error mid-sequence, then reset mid-Pause
    send(8'hE0);
    scan_code_error = 1'b1;
    cycle();
    scan_code_error = 1'b0;
    chk("t6_rx_err", err_count, 2);
    send(8'h1C);
    chk("t6_after_evt", {key_valid, key_extended, key_release, key_code}, 11'h41C);
    idle(2);
    send(8'hE1); send(8'h14);
    do_reset();
    send(8'h1C);
    chk("t6_post_rst_evt", {key_valid, key_extended, key_release, key_code}, 11'h41C);
    chk("t6_post_rst_err", err_count, 0);
    idle(2);

    // randomised traffic
    for (int blk = 0; blk < 8; blk++) begin
      int kr_pct;
      kr_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
      for (int i = 0; i < 500; i++) begin
        int r;
        r               = $urandom_range(0, 199);
        key_ready       = ($urandom_range(0, 99) < kr_pct);
        overflow_clr    = ($urandom_range(0, 30) == 0);
        scan_code_ready = 1'b0;
        scan_code_error = 1'b0;
        if (r < 80) begin
          scan_code_ready = 1'b1;
          scan_code       = pick_byte();
        end else if (r < 84) begin
          scan_code_error = 1'b1;
        end
        if (r == 199) idle(TMO + 3);
        else cycle();
      end
    end
    scan_code_ready = 1'b0;
    overflow_clr    = 1'b0;

    // error counter saturation
    scan_code_error = 1'b1;
    repeat (300) cycle();
    scan_code_error = 1'b0;
    chk("sat_err", err_count, 8'hFF);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
